// File: rtl/pong_bat_input_if.sv
// Bat input bundle between the AVR/SPI decoder + video timing (master side)
// and the bat motion generator (slave side).
//   vsync            : game vertical sync, rising edge = frame tick
//   key_stb/up/dn    : keyboard strobe with Q/A held flags
//   msy_stb/mouse_y  : mouse strobe with absolute 8-bit Y counter
//   l_human/r_human  : sticky human-control flags
//   lbat_move/rbat_move : signed per-frame bat velocities
//   frame_stb        : pulse in the cycle new velocities appear
interface pong_bat_input_if;
    logic              vsync;
    logic              key_stb;
    logic              key_up;
    logic              key_dn;
    logic              msy_stb;
    logic [7:0]        mouse_y;
    logic              l_human;
    logic signed [8:0] lbat_move;
    logic              r_human;
    logic signed [8:0] rbat_move;
    logic              frame_stb;

    modport master (
        output vsync, key_stb, key_up, key_dn, msy_stb, mouse_y,
        input  l_human, lbat_move, r_human, rbat_move, frame_stb
    );

    modport slave (
        input  vsync, key_stb, key_up, key_dn, msy_stb, mouse_y,
        output l_human, lbat_move, r_human, rbat_move, frame_stb
    );
endinterface

// File: rtl/pong_bat_input.sv
// Per-frame bat motion generator: turns keyboard strobes into a ramping left
// bat velocity and accumulated mouse-Y deltas into a right bat velocity, both
// frame-constant and updated on the rising edge of vsync.
//   fclk       : system clock
//   game_reset : asynchronous active-high reset
//   bus        : pong_bat_input_if slave (inputs, velocities, human flags)
module pong_bat_input #(
    parameter int unsigned RAMP_FRAMES  = 8,
    parameter int unsigned MOUSE_SETTLE = 7,
    parameter int unsigned MAX_MOVE     = 63
) (
    input  logic             fclk,
    input  logic             game_reset,
    pong_bat_input_if.slave  bus
);
    localparam int unsigned RAMP_W   = 4;
    localparam int unsigned SETTLE_W = (MOUSE_SETTLE < 1) ? 1 : $clog2(MOUSE_SETTLE + 1);
    localparam int unsigned ACC_W    = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOW = 2'd1;
    localparam logic [1:0] ST_MED  = 2'd2;
    localparam logic [1:0] ST_FAST = 2'd3;

    // Direction codes: up = negative velocity, down = positive
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_DN   = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;

    localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_MOVE);
    localparam logic signed [ACC_W-1:0] MIN_S = -MAX_S;

    logic                       prev_vsync_q;
    logic                       key_up_q, key_up_d;
    logic                       key_dn_q, key_dn_d;
    logic                       l_human_q, l_human_d;
    logic                       r_human_q, r_human_d;
    logic [1:0]                 state_q, state_d;
    logic [RAMP_W-1:0]          ramp_q, ramp_d;
    logic [1:0]                 last_dir_q, last_dir_d;
    logic signed [8:0]          lbat_q, lbat_d;
    logic signed [8:0]          rbat_q, rbat_d;
    logic                       frame_stb_q, frame_stb_d;
    logic [SETTLE_W-1:0]        settle_q, settle_d;
    logic [7:0]                 prev_y_q, prev_y_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;

    logic                       tick_c;
    logic [1:0]                 dir_c;
    logic [3:0]                 speed_c;
    logic [8:0]                 mag_c;
    logic                       accept_c;
    logic [7:0]                 diff_c;
    logic signed [ACC_W-1:0]    sum_c;

    assign tick_c = bus.vsync & ~prev_vsync_q;

    // Direction comes from the held keys, so a strobe in the tick cycle
    // only affects the following tick.
    always_comb begin
        dir_c = DIR_NONE;
        if (key_up_q && !key_dn_q) dir_c = DIR_UP;
        if (key_dn_q && !key_up_q) dir_c = DIR_DN;
    end

    // Keyboard speed FSM and left velocity
    always_comb begin
        state_d    = state_q;
        ramp_d     = ramp_q;
        last_dir_d = last_dir_q;
        lbat_d     = lbat_q;
        speed_c    = 4'd0;
        mag_c      = 9'd0;
        if (tick_c) begin
            last_dir_d = dir_c;
            if (dir_c == DIR_NONE) begin
                state_d = ST_IDLE;
                ramp_d  = '0;
            end else if (state_q == ST_IDLE || dir_c != last_dir_q) begin
                state_d = ST_SLOW;
                ramp_d  = '0;
            end else if (state_q != ST_FAST) begin
                if (ramp_q == RAMP_W'(RAMP_FRAMES - 1)) begin
                    ramp_d  = '0;
                    state_d = (state_q == ST_SLOW) ? ST_MED : ST_FAST;
                end else begin
                    ramp_d = ramp_q + RAMP_W'(1);
                end
            end
            case (state_d)
                ST_SLOW: speed_c = 4'd2;
                ST_MED:  speed_c = 4'd4;
                ST_FAST: speed_c = 4'd8;
                default: speed_c = 4'd0;
            endcase
            mag_c  = (9'(speed_c) > 9'(MAX_MOVE)) ? 9'(MAX_MOVE) : 9'(speed_c);
            lbat_d = (dir_c == DIR_UP) ? -$signed(mag_c) : $signed(mag_c);
        end
    end

    // Mouse accumulation; a strobe in the tick cycle starts the next frame
    always_comb begin
        diff_c    = bus.mouse_y - prev_y_q;
        accept_c  = bus.msy_stb && (settle_q == '0);
        sum_c     = (tick_c ? ACC_W'(0) : acc_q) + $signed({{2{diff_c[7]}}, diff_c});
        if (sum_c > MAX_S) sum_c = MAX_S;
        if (sum_c < MIN_S) sum_c = MIN_S;

        acc_d     = tick_c ? '0 : acc_q;
        if (accept_c) acc_d = sum_c;
        rbat_d    = tick_c ? acc_q[8:0] : rbat_q;
        settle_d  = (tick_c && settle_q != '0) ? settle_q - SETTLE_W'(1) : settle_q;
        prev_y_d  = bus.msy_stb ? bus.mouse_y : prev_y_q;
        r_human_d = r_human_q | accept_c;
    end

    // Key latch and frame strobe
    always_comb begin
        key_up_d    = bus.key_stb ? bus.key_up : key_up_q;
        key_dn_d    = bus.key_stb ? bus.key_dn : key_dn_q;
        l_human_d   = l_human_q | (bus.key_stb & (bus.key_up | bus.key_dn));
        frame_stb_d = tick_c;
    end

    // prev_vsync resets high so reset release never fakes a tick
    always_ff @(posedge fclk or posedge game_reset) begin
        if (game_reset) begin
            prev_vsync_q <= 1'b1;
            key_up_q     <= 1'b0;
            key_dn_q     <= 1'b0;
            l_human_q    <= 1'b0;
            r_human_q    <= 1'b0;
            state_q      <= ST_IDLE;
            ramp_q       <= '0;
            last_dir_q   <= DIR_NONE;
            lbat_q       <= '0;
            rbat_q       <= '0;
            frame_stb_q  <= 1'b0;
            settle_q     <= SETTLE_W'(MOUSE_SETTLE);
            prev_y_q     <= '0;
            acc_q        <= '0;
        end else begin
            prev_vsync_q <= bus.vsync;
            key_up_q     <= key_up_d;
            key_dn_q     <= key_dn_d;
            l_human_q    <= l_human_d;
            r_human_q    <= r_human_d;
            state_q      <= state_d;
            ramp_q       <= ramp_d;
            last_dir_q   <= last_dir_d;
            lbat_q       <= lbat_d;
            rbat_q       <= rbat_d;
            frame_stb_q  <= frame_stb_d;
            settle_q     <= settle_d;
            prev_y_q     <= prev_y_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.l_human   = l_human_q;
    assign bus.r_human   = r_human_q;
    assign bus.lbat_move = lbat_q;
    assign bus.rbat_move = rbat_q;
    assign bus.frame_stb = frame_stb_q;
endmodule

// File: tb/tb_pong_bat_input.sv
// Scoreboard bench for pong_bat_input: each issued frame tick pushes its
// hand-computed velocities; a monitor pops and compares on every frame_stb.
module tb_pong_bat_input;
    logic fclk;
    logic game_reset;

    pong_bat_input_if bus ();

    pong_bat_input #(
        .RAMP_FRAMES  (8),
        .MOUSE_SETTLE (7),
        .MAX_MOVE     (63)
    ) dut (
        .fclk       (fclk),
        .game_reset (game_reset),
        .bus        (bus)
    );

    typedef struct {
        int l;
        int r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic key(input logic up, input logic dn);
        bus.key_stb = 1'b1;
        bus.key_up  = up;
        bus.key_dn  = dn;
        cyc(1);
        bus.key_stb = 1'b0;
    endtask

    task automatic mouse(input logic [7:0] y);
        bus.msy_stb = 1'b1;
        bus.mouse_y = y;
        cyc(1);
        bus.msy_stb = 1'b0;
    endtask

    task automatic frame(input int el, input int er);
        exp_q.push_back('{l: el, r: er});
        bus.vsync = 1'b1;
        cyc(1);
        bus.vsync = 1'b0;
        cyc(1);
    endtask

    // Monitor: compare every presented frame against the scoreboard
    always @(negedge fclk) begin
        if (!done && bus.frame_stb) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame_stb: got lbat=%0d rbat=%0d, expected no frame",
                         bus.lbat_move, bus.rbat_move);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_lbat_move", int'(bus.lbat_move), e.l);
                check("frame_rbat_move", int'(bus.rbat_move), e.r);
            end
        end
    end

    initial begin
        game_reset  = 1'b1;
        bus.vsync   = 1'b0;
        bus.key_stb = 1'b0;
        bus.key_up  = 1'b0;
        bus.key_dn  = 1'b0;
        bus.msy_stb = 1'b0;
        bus.mouse_y = 8'd0;
        cyc(3);
        game_reset = 1'b0;
        cyc(1);

        check("reset_l_human",   int'(bus.l_human), 0);
        check("reset_r_human",   int'(bus.r_human), 0);
        check("reset_lbat_move", int'(bus.lbat_move), 0);
        check("reset_rbat_move", int'(bus.rbat_move), 0);
        check("reset_frame_stb", int'(bus.frame_stb), 0);

        // Mouse strobes during settling are ignored for motion
        mouse(8'd10);
        mouse(8'd12);
        check("settle_r_human", int'(bus.r_human), 0);

        // Keyboard ramp: 8 frames slow, 8 medium, then fast
        key(1'b1, 1'b0);
        check("key_l_human", int'(bus.l_human), 1);
        for (int i = 1; i <= 20; i++)
            frame((i <= 8) ? -2 : (i <= 16) ? -4 : -8, 0);
        key(1'b0, 1'b0);
        frame(0, 0);
        check("l_human_sticky", int'(bus.l_human), 1);

        // Settled now; first delta wraps: 0xFE-12 = -14, then 0x02-0xFE = +4
        mouse(8'hFE);
        check("accept_r_human", int'(bus.r_human), 1);
        mouse(8'h02);
        frame(0, -10);

        // Ramp to FAST, then reverse and press both
        key(1'b1, 1'b0);
        for (int i = 1; i <= 17; i++)
            frame((i <= 8) ? -2 : (i <= 16) ? -4 : -8, 0);
        key(1'b0, 1'b1);
        frame(2, 0);
        key(1'b1, 1'b1);
        frame(0, 0);

        // Saturation: +40, +40 (clamp 63), -5
        mouse(8'd42);
        mouse(8'd82);
        mouse(8'd77);
        frame(0, 58);
        mouse(8'd78);
        mouse(8'd79);
        mouse(8'd80);
        frame(0, 3);
        frame(0, 0);

        // Tick with mouse (+5) and key strobe in the same cycle, acc = 7
        mouse(8'd87);
        exp_q.push_back('{l: 0, r: 7});
        bus.vsync   = 1'b1;
        bus.msy_stb = 1'b1;
        bus.mouse_y = 8'd92;
        bus.key_stb = 1'b1;
        bus.key_up  = 1'b1;
        bus.key_dn  = 1'b0;
        cyc(1);
        bus.vsync   = 1'b0;
        bus.msy_stb = 1'b0;
        bus.key_stb = 1'b0;
        cyc(1);
        frame(-2, 5);

        // Mid-frame async reset with acc = 8
        mouse(8'd100);
        game_reset = 1'b1;
        #2;
        check("midreset_l_human",   int'(bus.l_human), 0);
        check("midreset_r_human",   int'(bus.r_human), 0);
        check("midreset_lbat_move", int'(bus.lbat_move), 0);
        check("midreset_rbat_move", int'(bus.rbat_move), 0);
        cyc(2);
        game_reset = 1'b0;
        cyc(1);
        check("postreset_frame_stb", int'(bus.frame_stb), 0);

        // Settle restored and acc cleared
        mouse(8'd50);
        check("postreset_r_human", int'(bus.r_human), 0);
        frame(0, 0);
        cyc(3);

        done = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pong_bat_input.md
# pong_bat_input

Per-frame bat motion generator for the pong core. Converts keyboard strobes (Q/A) and absolute mouse-Y samples, already decoded from the AVR SPI link, into frame-constant signed bat velocities and human/AI flags for the tennis game engine. It sits directly upstream of the game engine's `lbat_*` and `rbat_*` inputs and is frame-synchronised to the game's `vsync`.

## Interface
- `RAMP_FRAMES`, 8: frames spent in each keyboard speed step before advancing (1..15).
- `MOUSE_SETTLE`, 7: frame ticks after reset during which mouse strobes are ignored for motion.
- `MAX_MOVE`, 63: saturation magnitude of either bat velocity (1..255).
- `fclk` in 1: system clock.
- `game_reset` in 1: asynchronous, active-high reset.
- `vsync` in 1: game vertical sync, fclk domain; its rising edge is the frame tick.
- `key_stb` in 1: one-cycle strobe; `key_up` / `key_dn` are valid in that cycle.
- `key_up` in 1: Q held.
- `key_dn` in 1: A held.
- `msy_stb` in 1: one-cycle strobe; `mouse_y` is valid in that cycle.
- `mouse_y` in 8: absolute mouse Y counter, wraps modulo 256.
- `l_human` out 1: left bat under keyboard control (sticky).
- `lbat_move` out 9: signed left-bat velocity for the current frame; negative means up.
- `r_human` out 1: right bat under mouse control (sticky).
- `rbat_move` out 9: signed right-bat velocity for the current frame.
- `frame_stb` out 1: one-cycle pulse, asserted in the cycle new move values first appear.

## Operation
- **Frame tick**: `tick = vsync & ~prev_vsync`. `prev_vsync` is registered every cycle and resets to 1, so no tick occurs immediately after reset.
- **Key latch**: on `key_stb`, store `key_up` and `key_dn` into held registers. Also on `key_stb`, if `key_up | key_dn`, set `l_human` to 1.
- **Direction**: derived from the held keys.
  - up only: -1
  - down only: +1
  - both or neither: 0
- **Keyboard FSM**: states IDLE, SLOW, MED, FAST. Evaluated only on a tick.
  - dir = 0: go to IDLE.
  - dir ≠ 0 and (state is IDLE, or dir differs from the direction latched at the previous tick): go to SLOW and clear the ramp counter.
  - Otherwise the ramp counter increments. When the counter reaches `RAMP_FRAMES`-1: SLOW→MED and MED→FAST, counter cleared. FAST holds.
- **Left velocity**: on a tick, `lbat_move` ← dir × speed, using the next state's speed.
  - IDLE = 0, SLOW = 2, MED = 4, FAST = 8.
  - The result is clamped to ±`MAX_MOVE`.
- **Mouse settle counter**: starts at `MOUSE_SETTLE` and decrements on each tick until it reaches 0.
- **Mouse strobes**:
  - Every `msy_stb` updates `prev_y` ← `mouse_y`, including during settling.
  - A strobe is accepted only when settle = 0.
  - An accepted strobe sets `r_human` to 1 (sticky).
  - An accepted strobe adds `delta = sext9(mouse_y - prev_y)` to the 10-bit signed accumulator `acc`. The 8-bit difference wraps: 0x02 - 0xFE = +4. The sum is clamped to ±`MAX_MOVE`.
- **Right velocity**: on a tick, `rbat_move` ← `acc`, then `acc` ← 0.
- **Tick and mouse strobe in the same cycle**: `rbat_move` takes the old `acc`, and `acc` ← the clamped delta, so the delta counts toward the next frame. The settle decision uses the pre-tick settle value.
- **Tick and key strobe in the same cycle**: the FSM uses the held keys from before the strobe; new keys take effect at the next tick.

## Timing
- Reset values:
  - outputs: `l_human` = 0, `r_human` = 0, `lbat_move` = 0, `rbat_move` = 0, `frame_stb` = 0.
  - internal: FSM IDLE, ramp counter 0, held keys 0, `acc` = 0, `prev_y` = 0, settle = `MOUSE_SETTLE`.
- All state is updated on the fclk rising edge.
- `lbat_move`, `rbat_move` and `frame_stb` update on the edge that samples the tick, so they are visible 1 cycle after `vsync` is first seen high. They then hold until the next tick.
- `l_human` and `r_human` are visible 1 cycle after the qualifying strobe.
- `game_reset` is asynchronous: it returns every register to its reset value mid-frame, with no tick generated.
- No backpressure: strobes are accepted every cycle, including back-to-back.

## Test plan
- **Reset defaults**: assert `game_reset` mid-frame with `acc` ≠ 0 → all outputs are 0 immediately, and there is no `frame_stb` on the next cycle.
- **Keyboard ramp**: `key_stb` with up = 1, dn = 0, `RAMP_FRAMES` = 8 → `l_human` = 1; `lbat_move` reads -2 for frames 1–8, -4 for frames 9–16, then -8 from frame 17. `key_stb` with 0/0 → 0 at the next tick.
- **Direction reversal**: in FAST up, `key_stb` with dn = 1 → next tick gives `lbat_move` = +2. Both keys pressed → 0.
- **Mouse settle and wrap**: strobes 10, 12 during settling → `r_human` stays 0 and `rbat_move` = 0. After 7 ticks, strobes 0xFE then 0x02 → `rbat_move` = +4 is more than that; expected value is sext(0xFE - 12) + 4 = -14 + 4 = -10 at the next tick.
- **Saturation and accumulation**: accepted deltas +40, +40, -5 within one frame → `rbat_move` = +58 (clamped to 63 after the second delta, then 63 - 5). With deltas +1 ×3 the value is +3, and the frame after is 0.
- **Simultaneous events**: `msy_stb` with delta +5 in the tick cycle, `acc` = 7 → `rbat_move` = 7 now, then 5 at the next tick. `key_stb` in the tick cycle → the new keys affect only the next tick.
